// File: rtl/tl_rx_flow_control.sv
// Receive-side flow-control engine: tracks allocated/received credits per class,
// flags receiver overflow and schedules UpdateFC requests. Optional macro TL_RX_FC_TIMER_EN.
module tl_rx_flow_control #(
    parameter int PH_INIT   = 32,
    parameter int PD_INIT   = 256,
    parameter int NH_INIT   = 32,
    parameter int CH_INIT   = 32,
    parameter int CD_INIT   = 256,
    parameter int TIMER_LG2 = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        link_up_i,
    input  logic        rx_tlp_valid_i,
    input  logic [1:0]  rx_tlp_type_i,
    input  logic [11:0] rx_tlp_dcred_i,
    input  logic        p_hdr_rden_i,
    input  logic        np_hdr_rden_i,
    input  logic        cpl_hdr_rden_i,
    input  logic        p_data_rden_i,
    input  logic        cpl_data_rden_i,
    output logic [11:0] init_ph_o,
    output logic [11:0] init_pd_o,
    output logic [11:0] init_nh_o,
    output logic [11:0] init_ch_o,
    output logic [11:0] init_cd_o,
    output logic        fc_req_o,
    output logic [1:0]  fc_type_o,
    output logic [11:0] fc_hdr_o,
    output logic [11:0] fc_data_o,
    input  logic        fc_ack_i,
    output logic        overflow_err_o,
    output logic [1:0]  overflow_type_o
);
    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    localparam logic [11:0] PH0 = 12'(PH_INIT);
    localparam logic [11:0] PD0 = 12'(PD_INIT);
    localparam logic [11:0] NH0 = 12'(NH_INIT);
    localparam logic [11:0] CH0 = 12'(CH_INIT);
    localparam logic [11:0] CD0 = 12'(CD_INIT);

    assign init_ph_o = PH0;
    assign init_pd_o = PD0;
    assign init_nh_o = NH0;
    assign init_ch_o = CH0;
    assign init_cd_o = CD0;

    state_t      state_q, state_d;
    logic [11:0] ph_q, pd_q, nh_q, ch_q, cd_q;
    logic [11:0] ph_d, pd_d, nh_d, ch_d, cd_d;
    logic [11:0] rph_q, rpd_q, rnh_q, rch_q, rcd_q;
    logic [2:0]  pend_q, pend_d, pend_nxt, grant, rden_cls;
    logic [1:0]  snap_type;
    logic [11:0] snap_hdr, snap_data;
    logic        timer_wrap;
    logic        rx_p, rx_np, rx_cpl;
    logic [11:0] dph, dpd, dnh, dch, dcd;
    logic [2:0]  ovf;

    // Next allocated values feed the snapshot so same-cycle drains are included.
    assign ph_d = ph_q + {11'd0, p_hdr_rden_i};
    assign pd_d = pd_q + (p_data_rden_i ? 12'd2 : 12'd0);
    assign nh_d = nh_q + {11'd0, np_hdr_rden_i};
    assign ch_d = ch_q + {11'd0, cpl_hdr_rden_i};
    assign cd_d = cd_q + (cpl_data_rden_i ? 12'd2 : 12'd0);

    assign rden_cls = {cpl_hdr_rden_i | cpl_data_rden_i, np_hdr_rden_i,
                       p_hdr_rden_i | p_data_rden_i};

    assign rx_p   = rx_tlp_valid_i && (rx_tlp_type_i == 2'd0);
    assign rx_np  = rx_tlp_valid_i && (rx_tlp_type_i == 2'd1);
    assign rx_cpl = rx_tlp_valid_i && (rx_tlp_type_i == 2'd2);

    assign dph = ph_q - rph_q;
    assign dpd = pd_q - rpd_q;
    assign dnh = nh_q - rnh_q;
    assign dch = ch_q - rch_q;
    assign dcd = cd_q - rcd_q;
    assign ovf = {dch[11] | dcd[11], dnh[11], dph[11] | dpd[11]};

`ifdef TL_RX_FC_TIMER_EN
    logic [TIMER_LG2-1:0] timer_q;
    assign timer_wrap = &timer_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          timer_q <= '0;
        else if (!link_up_i) timer_q <= '0;
        else                 timer_q <= timer_q + TIMER_LG2'(1);
    end
`else
    logic [TIMER_LG2-1:0] timer_unused;
    assign timer_unused = '0;
    assign timer_wrap   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        grant     = 3'b000;
        pend_d    = pend_q | rden_cls | {3{timer_wrap}};
        snap_type = 2'd0;
        snap_hdr  = ph_d;
        snap_data = pd_d;
        case (state_q)
            IDLE: begin
                if (pend_d[0]) begin
                    grant = 3'b001;
                end else if (pend_d[1]) begin
                    grant     = 3'b010;
                    snap_type = 2'd1;
                    snap_hdr  = nh_d;
                    snap_data = 12'd0;
                end else if (pend_d[2]) begin
                    grant     = 3'b100;
                    snap_type = 2'd2;
                    snap_hdr  = ch_d;
                    snap_data = cd_d;
                end
                if (|pend_d) state_d = REQ;
            end
            REQ:     if (fc_ack_i) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        pend_nxt = pend_d & ~grant;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || !link_up_i) begin
            state_q  <= IDLE;
            pend_q   <= 3'b000;
            ph_q <= PH0; pd_q <= PD0; nh_q <= NH0; ch_q <= CH0; cd_q <= CD0;
            rph_q <= '0; rpd_q <= '0; rnh_q <= '0; rch_q <= '0; rcd_q <= '0;
            fc_req_o  <= 1'b0;
            fc_type_o <= 2'd0;
            fc_hdr_o  <= '0;
            fc_data_o <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_nxt;
            ph_q <= ph_d; pd_q <= pd_d; nh_q <= nh_d; ch_q <= ch_d; cd_q <= cd_d;
            if (rx_p) begin
                rph_q <= rph_q + 12'd1;
                rpd_q <= rpd_q + rx_tlp_dcred_i;
            end
            if (rx_np) rnh_q <= rnh_q + 12'd1;
            if (rx_cpl) begin
                rch_q <= rch_q + 12'd1;
                rcd_q <= rcd_q + rx_tlp_dcred_i;
            end
            fc_req_o <= (state_d == REQ);
            if (|grant) begin
                fc_type_o <= snap_type;
                fc_hdr_o  <= snap_hdr;
                fc_data_o <= snap_data;
            end
        end
    end

    // Sticky error survives link drops; only rst_n clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_err_o  <= 1'b0;
            overflow_type_o <= 2'd0;
        end else if (!overflow_err_o && (|ovf)) begin
            overflow_err_o  <= 1'b1;
            overflow_type_o <= ovf[0] ? 2'd0 : (ovf[1] ? 2'd1 : 2'd2);
        end
    end
endmodule

// File: tb/tb_tl_rx_flow_control.sv
// Directed bench for tl_rx_flow_control; each task drives one scenario and checks inline.
module tb_tl_rx_flow_control;
    logic        clk = 1'b0;
    logic        rst_n, link_up, rx_valid, fc_ack;
    logic [1:0]  rx_type;
    logic [11:0] rx_dcred;
    logic        p_hdr, np_hdr, cpl_hdr, p_data, cpl_data;
    logic [11:0] init_ph, init_pd, init_nh, init_ch, init_cd;
    logic        fc_req, ovf_err;
    logic [1:0]  fc_type, ovf_type;
    logic [11:0] fc_hdr, fc_data;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tl_rx_flow_control #(.TIMER_LG2(4)) dut (
        .clk(clk), .rst_n(rst_n), .link_up_i(link_up),
        .rx_tlp_valid_i(rx_valid), .rx_tlp_type_i(rx_type), .rx_tlp_dcred_i(rx_dcred),
        .p_hdr_rden_i(p_hdr), .np_hdr_rden_i(np_hdr), .cpl_hdr_rden_i(cpl_hdr),
        .p_data_rden_i(p_data), .cpl_data_rden_i(cpl_data),
        .init_ph_o(init_ph), .init_pd_o(init_pd), .init_nh_o(init_nh),
        .init_ch_o(init_ch), .init_cd_o(init_cd),
        .fc_req_o(fc_req), .fc_type_o(fc_type), .fc_hdr_o(fc_hdr), .fc_data_o(fc_data),
        .fc_ack_i(fc_ack), .overflow_err_o(ovf_err), .overflow_type_o(ovf_type)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; link_up = 1'b0; rx_valid = 1'b0; rx_type = 2'd0; rx_dcred = '0;
        p_hdr = 1'b0; np_hdr = 1'b0; cpl_hdr = 1'b0; p_data = 1'b0; cpl_data = 1'b0;
        fc_ack = 1'b0;
        step(); step();
        rst_n = 1'b1; link_up = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if ({fc_req, fc_type, fc_hdr, fc_data, ovf_err, ovf_type} !== 30'd0) begin
            bad++;
            $display("FAIL reset_outputs got req=%0b type=%0d hdr=%0d data=%0d err=%0b etype=%0d want all 0",
                     fc_req, fc_type, fc_hdr, fc_data, ovf_err, ovf_type);
        end
        total++;
        if (init_ph !== 12'd32 || init_pd !== 12'd256 || init_nh !== 12'd32 ||
            init_ch !== 12'd32 || init_cd !== 12'd256) begin
            bad++;
            $display("FAIL init_values got %0d %0d %0d %0d %0d want 32 256 32 32 256",
                     init_ph, init_pd, init_nh, init_ch, init_cd);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_idle_quiet();
        int seen = 0;
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            step();
            if (fc_req) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL idle_quiet got %0d request cycles want 0", seen);
        end
    endtask

    task automatic test_p_snapshot();
        do_reset();
        np_hdr = 1'b1;
        step();
        np_hdr = 1'b0;
        total++;
        if (fc_req !== 1'b1 || fc_type !== 2'd1 || fc_hdr !== 12'd33 || fc_data !== 12'd0) begin
            bad++;
            $display("FAIL np_blocker got req=%0b type=%0d hdr=%0d data=%0d want 1 1 33 0",
                     fc_req, fc_type, fc_hdr, fc_data);
        end
        p_hdr = 1'b1; p_data = 1'b1;
        step();
        p_hdr = 1'b0;
        total++;
        if (fc_type !== 2'd1 || fc_hdr !== 12'd33) begin
            bad++;
            $display("FAIL np_held got type=%0d hdr=%0d want 1 33", fc_type, fc_hdr);
        end
        step();
        p_data = 1'b0; fc_ack = 1'b1;
        step();
        fc_ack = 1'b0;
        total++;
        if (fc_req !== 1'b0) begin
            bad++;
            $display("FAIL np_ack_drop got req=%0b want 0", fc_req);
        end
        step();
        total++;
        if (fc_req !== 1'b0) begin
            bad++;
            $display("FAIL gap_idle got req=%0b want 0", fc_req);
        end
        step();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (fc_req !== 1'b1 || fc_type !== 2'd0 || fc_hdr !== 12'd33 || fc_data !== 12'd260) begin
                bad++;
                $display("FAIL p_snapshot[%0d] got req=%0b type=%0d hdr=%0d data=%0d want 1 0 33 260",
                         i, fc_req, fc_type, fc_hdr, fc_data);
            end
            if (i < 2) step();
        end
        fc_ack = 1'b1;
        step();
        fc_ack = 1'b0;
        total++;
        if (fc_req !== 1'b0) begin
            bad++;
            $display("FAIL p_ack_drop got req=%0b want 0", fc_req);
        end
        for (int i = 0; i < 6; i++) step();
        total++;
        if (fc_req !== 1'b0) begin
            bad++;
            $display("FAIL p_single got req=%0b want 0", fc_req);
        end
    endtask

    task automatic test_priority();
        do_reset();
        np_hdr = 1'b1; cpl_hdr = 1'b1;
        step();
        np_hdr = 1'b0; cpl_hdr = 1'b0;
        total++;
        if (fc_req !== 1'b1 || fc_type !== 2'd1 || fc_hdr !== 12'd33 || fc_data !== 12'd0) begin
            bad++;
            $display("FAIL prio_np got req=%0b type=%0d hdr=%0d data=%0d want 1 1 33 0",
                     fc_req, fc_type, fc_hdr, fc_data);
        end
        fc_ack = 1'b1;
        step();
        fc_ack = 1'b0;
        step();
        total++;
        if (fc_req !== 1'b0) begin
            bad++;
            $display("FAIL prio_gap got req=%0b want 0", fc_req);
        end
        step();
        total++;
        if (fc_req !== 1'b1 || fc_type !== 2'd2 || fc_hdr !== 12'd33 || fc_data !== 12'd256) begin
            bad++;
            $display("FAIL prio_cpl got req=%0b type=%0d hdr=%0d data=%0d want 1 2 33 256",
                     fc_req, fc_type, fc_hdr, fc_data);
        end
        fc_ack = 1'b1;
        step();
        fc_ack = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        rx_valid = 1'b1; rx_type = 2'd0; rx_dcred = 12'd0;
        for (int i = 0; i < 33; i++) step();
        rx_valid = 1'b0;
        total++;
        if (ovf_err !== 1'b0) begin
            bad++;
            $display("FAIL ovf_early got err=%0b want 0", ovf_err);
        end
        step();
        total++;
        if (ovf_err !== 1'b1 || ovf_type !== 2'd0) begin
            bad++;
            $display("FAIL ovf_p got err=%0b type=%0d want 1 0", ovf_err, ovf_type);
        end
        rx_valid = 1'b1; rx_type = 2'd2;
        for (int i = 0; i < 33; i++) step();
        rx_valid = 1'b0;
        step(); step();
        total++;
        if (ovf_err !== 1'b1 || ovf_type !== 2'd0) begin
            bad++;
            $display("FAIL ovf_sticky got err=%0b type=%0d want 1 0", ovf_err, ovf_type);
        end
    endtask

    task automatic test_link_drop();
        np_hdr = 1'b1;
        step();
        np_hdr = 1'b0;
        total++;
        if (fc_req !== 1'b1) begin
            bad++;
            $display("FAIL drop_req got req=%0b want 1", fc_req);
        end
        link_up = 1'b0;
        step();
        total++;
        if (fc_req !== 1'b0 || fc_hdr !== 12'd0 || ovf_err !== 1'b1 || ovf_type !== 2'd0) begin
            bad++;
            $display("FAIL drop_state got req=%0b hdr=%0d err=%0b type=%0d want 0 0 1 0",
                     fc_req, fc_hdr, ovf_err, ovf_type);
        end
        link_up = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (fc_req !== 1'b0) begin
                total++; bad++;
                $display("FAIL drop_quiet got req=1 at cycle %0d want 0", i);
                break;
            end
        end
        total++;
        if (ovf_err !== 1'b1) begin
            bad++;
            $display("FAIL drop_keep_err got err=%0b want 1", ovf_err);
        end
    endtask

    task automatic test_data_overflow();
        do_reset();
        rx_valid = 1'b1; rx_type = 2'd2; rx_dcred = 12'd256;
        step();
        rx_valid = 1'b0;
        step(); step();
        total++;
        if (ovf_err !== 1'b0) begin
            bad++;
            $display("FAIL cd_boundary got err=%0b want 0", ovf_err);
        end
        rx_valid = 1'b1; rx_dcred = 12'd1;
        step();
        rx_valid = 1'b0;
        step();
        total++;
        if (ovf_err !== 1'b1 || ovf_type !== 2'd2) begin
            bad++;
            $display("FAIL cd_overflow got err=%0b type=%0d want 1 2", ovf_err, ovf_type);
        end
    endtask

    task automatic wait_req(input logic [1:0] t, input logic [11:0] h, input logic [11:0] d,
                            output int at);
        int n = 0;
        while (!fc_req && n < 40) begin
            step();
            n++;
        end
        at = cyc;
        total++;
        if (fc_req !== 1'b1 || fc_type !== t || fc_hdr !== h || fc_data !== d) begin
            bad++;
            $display("FAIL timer_req got req=%0b type=%0d hdr=%0d data=%0d want 1 %0d %0d %0d",
                     fc_req, fc_type, fc_hdr, fc_data, t, h, d);
        end
        fc_ack = 1'b1;
        step();
        fc_ack = 1'b0;
    endtask

    task automatic test_timer();
        int t0, t1, tn;
        do_reset();
        wait_req(2'd0, 12'd32, 12'd256, t0);
        wait_req(2'd1, 12'd32, 12'd0, tn);
        wait_req(2'd2, 12'd32, 12'd256, tn);
        wait_req(2'd0, 12'd32, 12'd256, t1);
        total++;
        if (t1 - t0 !== 16) begin
            bad++;
            $display("FAIL timer_period got %0d want 16", t1 - t0);
        end
    endtask

    initial begin
        test_reset();
`ifdef TL_RX_FC_TIMER_EN
        test_timer();
`else
        test_idle_quiet();
        test_p_snapshot();
        test_priority();
        test_overflow();
        test_link_drop();
        test_data_overflow();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
